// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Operations: add, sub, mul (shift-add), div and mod (restoring division).
// Add, sub, illegal opcodes and divide-by-zero finish one cycle after
// acceptance. Mul, div and mod spend WIDTH cycles in BUSY.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   data0_i      operand A (unsigned)
//   data1_i      operand B (unsigned)
//   ctrl_i       opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod
//   valid_i      request valid
//   ready_o      high only in IDLE (and never while in reset)
//   result_o     primary result
//   result_hi_o  upper product half for mul, zero otherwise
//   carry_o      add carry / sub borrow / mul high half nonzero
//   zero_o       result_o == 0
//   err_o        divide-by-zero or illegal opcode
//   valid_o      result outputs valid (DONE state)
//   ready_i      downstream accepts the result
module alu_multiciclo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] data0_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [2:0]       ctrl_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             carry_o,
   output logic             zero_o,
   output logic             err_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpDiv = 3'b011;
   localparam logic [2:0] OpMod = 3'b100;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e               state_q;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     opnd_q;  // multiplicand for mul, divisor for div/mod
   logic [2*WIDTH-1:0]   prod_q;  // mul: {partial sum, multiplier}; div: {remainder, quotient}
   logic [CntW-1:0]      cnt_q;
   logic [WIDTH-1:0]     result_q;
   logic [WIDTH-1:0]     result_hi_q;
   logic                 carry_q;
   logic                 zero_q;
   logic                 err_q;

   logic                 accept;
   logic [WIDTH:0]       add_res;
   logic [WIDTH:0]       sub_res;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_trial;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;

   assign ready_o = (state_q == StIdle) && rst_ni;
   assign accept  = valid_i && ready_o;

   always_comb begin
      add_res = {1'b0, data0_i} + {1'b0, data1_i};
      // Top bit of the WIDTH+1 difference is the borrow.
      sub_res = {1'b0, data0_i} - {1'b0, data1_i};

      // One shift-add step: conditionally add multiplicand, shift right.
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};

      // One restoring step: shift in next dividend bit, subtract if it fits.
      div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd_q};
      if (!div_diff[WIDTH]) begin
         div_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      end

      step_next = (op_q == OpMul) ? mul_next : div_next;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         op_q        <= '0;
         opnd_q      <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q  <= ctrl_i;
                  cnt_q <= '0;
                  unique case (ctrl_i)
                     OpAdd: begin
                        result_q    <= add_res[WIDTH-1:0];
                        result_hi_q <= '0;
                        carry_q     <= add_res[WIDTH];
                        zero_q      <= (add_res[WIDTH-1:0] == '0);
                        err_q       <= 1'b0;
                        state_q     <= StDone;
                     end
                     OpSub: begin
                        result_q    <= sub_res[WIDTH-1:0];
                        result_hi_q <= '0;
                        carry_q     <= sub_res[WIDTH];
                        zero_q      <= (sub_res[WIDTH-1:0] == '0);
                        err_q       <= 1'b0;
                        state_q     <= StDone;
                     end
                     OpMul: begin
                        opnd_q  <= data0_i;
                        prod_q  <= {{WIDTH{1'b0}}, data1_i};
                        state_q <= StBusy;
                     end
                     OpDiv, OpMod: begin
                        if (data1_i == '0) begin
                           result_q    <= (ctrl_i == OpDiv) ? '1 : data0_i;
                           result_hi_q <= '0;
                           carry_q     <= 1'b0;
                           zero_q      <= (ctrl_i == OpMod) && (data0_i == '0);
                           err_q       <= 1'b1;
                           state_q     <= StDone;
                        end else begin
                           opnd_q  <= data1_i;
                           prod_q  <= {{WIDTH{1'b0}}, data0_i};
                           state_q <= StBusy;
                        end
                     end
                     default: begin
                        result_q    <= '0;
                        result_hi_q <= '0;
                        carry_q     <= 1'b0;
                        zero_q      <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= StDone;
                     end
                  endcase
               end
            end
            StBusy: begin
               prod_q <= step_next;
               cnt_q  <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  // Last step: publish results straight from the final step value.
                  state_q <= StDone;
                  err_q   <= 1'b0;
                  if (op_q == OpMul) begin
                     result_q    <= step_next[WIDTH-1:0];
                     result_hi_q <= step_next[2*WIDTH-1:WIDTH];
                     carry_q     <= (step_next[2*WIDTH-1:WIDTH] != '0);
                     zero_q      <= (step_next[WIDTH-1:0] == '0);
                  end else if (op_q == OpDiv) begin
                     result_q    <= step_next[WIDTH-1:0];
                     result_hi_q <= '0;
                     carry_q     <= 1'b0;
                     zero_q      <= (step_next[WIDTH-1:0] == '0);
                  end else begin
                     result_q    <= step_next[2*WIDTH-1:WIDTH];
                     result_hi_q <= '0;
                     carry_q     <= 1'b0;
                     zero_q      <= (step_next[2*WIDTH-1:WIDTH] == '0);
                  end
               end
            end
            StDone: begin
               if (ready_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign valid_o     = (state_q == StDone);
   assign result_o    = result_q;
   assign result_hi_o = result_hi_q;
   assign carry_o     = carry_q;
   assign zero_o      = zero_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic [W-1:0] data0_i, data1_i;
   logic [2:0]   ctrl_i;
   logic         valid_i, ready_o, ready_i;
   logic [W-1:0] result_o, result_hi_o;
   logic         carry_o, zero_o, err_o, valid_o;

   int errors = 0;
   int checks = 0;

   alu_multiciclo #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .data0_i     (data0_i),
      .data1_i     (data1_i),
      .ctrl_i      (ctrl_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .result_o    (result_o),
      .result_hi_o (result_hi_o),
      .carry_o     (carry_o),
      .zero_o      (zero_o),
      .err_o       (err_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model straight from the arithmetic definitions.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output logic [7:0] r, output logic [7:0] h, output logic c,
                        output logic e, output int lat);
      int unsigned ia, ib, p;
      ia = a; ib = b;
      r = 0; h = 0; c = 0; e = 0; lat = 1;
      case (op)
         3'd0: begin p = ia + ib; r = p[7:0]; c = (p > 255); end
         3'd1: begin p = ia - ib; r = p[7:0]; c = (ia < ib); end
         3'd2: begin p = ia * ib; r = p[7:0]; h = p[15:8]; c = (h != 0); lat = 9; end
         3'd3: if (ib == 0) begin r = 8'hFF; e = 1; end
               else begin p = ia / ib; r = p[7:0]; lat = 9; end
         3'd4: if (ib == 0) begin r = a; e = 1; end
               else begin p = ia % ib; r = p[7:0]; lat = 9; end
         default: e = 1;
      endcase
   endtask

   // Issue one request, wait for valid_o, check, hold DONE for `hold` cycles, release.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input int hold);
      logic [7:0] er, eh;
      logic       ec, ee;
      int         elat, lat;
      logic [7:0] held_r;
      model(a, b, op, er, eh, ec, ee, elat);
      check({tag, " ready_before"}, 32'(ready_o), 32'd1);
      data0_i = a; data1_i = b; ctrl_i = op; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      data0_i = 8'($urandom); data1_i = 8'($urandom); ctrl_i = 3'($urandom);
      lat = 1;
      while (!valid_o && lat <= 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " result"}, 32'(result_o), 32'(er));
      check({tag, " result_hi"}, 32'(result_hi_o), 32'(eh));
      check({tag, " carry"}, 32'(carry_o), 32'(ec));
      check({tag, " zero"}, 32'(zero_o), 32'(er == 0));
      check({tag, " err"}, 32'(err_o), 32'(ee));
      held_r = er;
      for (int i = 0; i < hold; i++) begin
         valid_i = 1'b1; data0_i = 8'($urandom); data1_i = 8'($urandom); ctrl_i = 3'd0;
         @(posedge clk); #1;
         check({tag, " hold_valid"}, 32'(valid_o), 32'd1);
         check({tag, " hold_result"}, 32'(result_o), 32'(held_r));
         check({tag, " hold_ready"}, 32'(ready_o), 32'd0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check({tag, " exit_valid"}, 32'(valid_o), 32'd0);
      check({tag, " exit_ready"}, 32'(ready_o), 32'd1);
      check({tag, " idle_result"}, 32'(result_o), 32'(held_r));
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] r;
      logic [7:0] h;
      logic       c;
      logic       e;
      int         lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int seen;
      vecs[0]  = '{8'hF0, 8'h20, 3'd0, 8'h10, 8'h00, 1'b1, 1'b0, 1};
      vecs[1]  = '{8'h05, 8'h05, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1};
      vecs[2]  = '{8'h03, 8'h05, 3'd1, 8'hFE, 8'h00, 1'b1, 1'b0, 1};
      vecs[3]  = '{8'hFF, 8'hFF, 3'd2, 8'h01, 8'hFE, 1'b1, 1'b0, 9};
      vecs[4]  = '{8'd200, 8'd7, 3'd3, 8'd28, 8'h00, 1'b0, 1'b0, 9};
      vecs[5]  = '{8'd200, 8'd7, 3'd4, 8'd4, 8'h00, 1'b0, 1'b0, 9};
      vecs[6]  = '{8'd9, 8'd0, 3'd3, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
      vecs[7]  = '{8'd9, 8'd0, 3'd4, 8'd9, 8'h00, 1'b0, 1'b1, 1};
      vecs[8]  = '{8'h05, 8'h03, 3'd7, 8'h00, 8'h00, 1'b0, 1'b1, 1};
      vecs[9]  = '{8'h10, 8'h0F, 3'd2, 8'hF0, 8'h00, 1'b0, 1'b0, 9};
      vecs[10] = '{8'd5, 8'd9, 3'd3, 8'd0, 8'h00, 1'b0, 1'b0, 9};
      vecs[11] = '{8'd5, 8'd9, 3'd4, 8'd5, 8'h00, 1'b0, 1'b0, 9};

      rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      data0_i = '0; data1_i = '0; ctrl_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 32'(ready_o), 32'd0);
      check("reset valid", 32'(valid_o), 32'd0);
      check("reset result", 32'(result_o), 32'd0);
      check("reset flags", 32'({result_hi_o, carry_o, zero_o, err_o}), 32'd0);
      rst_ni = 1'b1;
      #1;
      check("reset release ready", 32'(ready_o), 32'd1);

      // Table-driven vectors; independently check the hand-written expectations.
      foreach (vecs[i]) begin
         logic [7:0] r, h;
         logic       c, e;
         int         lat;
         model(vecs[i].a, vecs[i].b, vecs[i].op, r, h, c, e, lat);
         check($sformatf("vec%0d table", i), 32'({r, h, c, e, 8'(lat)}),
               32'({vecs[i].r, vecs[i].h, vecs[i].c, vecs[i].e, 8'(vecs[i].lat)}));
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, (i == 3) ? 5 : 0);
      end

      // DONE held for 5 cycles with valid_i stray requests.
      run_op("hold_illegal", 8'h12, 8'h34, 3'd7, 5);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         run_op($sformatf("rnd%0d", i), a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
      end

      // Reset at BUSY cycle 4 of a mul aborts it.
      check("abort ready_before", 32'(ready_o), 32'd1);
      data0_i = 8'hFF; data1_i = 8'hFF; ctrl_i = 3'd2; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort busy valid", 32'(valid_o), 32'd0);
      rst_ni = 1'b0;
      #1;
      check("abort ready in reset", 32'(ready_o), 32'd0);
      @(posedge clk); #1;
      check("abort valid", 32'(valid_o), 32'd0);
      check("abort result", 32'(result_o), 32'd0);
      check("abort flags", 32'({result_hi_o, carry_o, zero_o, err_o}), 32'd0);
      rst_ni = 1'b1;
      #1;
      check("abort release ready", 32'(ready_o), 32'd1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (valid_o) seen++;
      end
      check("abort no valid", 32'(seen), 32'd0);

      run_op("post_abort", 8'd200, 8'd7, 3'd3, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
